// File: rtl/alu_pkg.sv
// Shared ALU definitions: add/sub mode encoding and carry-lookahead group size.
package alu_pkg;

   typedef enum logic [1:0] {
      ADD  = 2'd0,
      SUB  = 2'd1,
      SADD = 2'd2,
      SSUB = 2'd3
   } alu_addsub_mode_e;

   localparam int CLA_GRP = 4;

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: sum plus group propagate/generate for the next lookahead level.
// Purely combinational, no latency and no flow control.
module cla_group4
   import alu_pkg::*;
(
   input  logic [CLA_GRP-1:0] a,
   input  logic [CLA_GRP-1:0] b,
   input  logic               cin,
   output logic [CLA_GRP-1:0] sum,
   output logic               gp,
   output logic               gg,
   output logic               cout
);

   logic [CLA_GRP-1:0] p;
   logic [CLA_GRP-1:0] g;
   logic [CLA_GRP-1:0] c;

   assign p = a ^ b;
   assign g = a & b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

   assign sum  = p ^ c;
   assign gp   = &p;
   assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign cout = gg | (gp & cin);

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined CLA add/sub with saturation and flags; latency STAGES cycles.
// One global advance: every register holds while out_valid && !out_ready, and in_ready drops.
module cla_addsub_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovfl,
   output logic             zero,
   output logic             neg
);

   localparam int SW = WIDTH / STAGES;
   localparam int NG = SW / CLA_GRP;
   localparam int L  = STAGES - 1;
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   generate
      if (STAGES < 1 || (WIDTH % (CLA_GRP * STAGES)) != 0) begin : g_bad_cfg
         $fatal(1, "cla_addsub_pipe: WIDTH must be a multiple of 4*STAGES and STAGES >= 1");
      end
   endgenerate

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Stage k inputs (s_*) and combinational slice results (n_*)
   logic             s_vld  [STAGES];
   logic [1:0]       s_mode [STAGES];
   logic [WIDTH-1:0] s_a    [STAGES];
   logic [WIDTH-1:0] s_bx   [STAGES];
   logic [WIDTH-1:0] s_sum  [STAGES];
   logic             s_c    [STAGES];
   logic [WIDTH-1:0] n_sum  [STAGES];
   logic             n_c    [STAGES];

   // Inter-stage registers; r_*[k] feeds stage k
   logic             r_vld  [1:STAGES-1];
   logic [1:0]       r_mode [1:STAGES-1];
   logic [WIDTH-1:0] r_a    [1:STAGES-1];
   logic [WIDTH-1:0] r_bx   [1:STAGES-1];
   logic [WIDTH-1:0] r_sum  [1:STAGES-1];
   logic             r_c    [1:STAGES-1];

   generate
      for (genvar k = 0; k < STAGES; k++) begin : g_stage
         if (k == 0) begin : g_in
            assign s_vld[k]  = in_valid;
            assign s_mode[k] = mode;
            assign s_a[k]    = a;
            assign s_bx[k]   = mode[0] ? ~b : b;
            assign s_sum[k]  = '0;
            assign s_c[k]    = mode[0];
         end else begin : g_reg
            assign s_vld[k]  = r_vld[k];
            assign s_mode[k] = r_mode[k];
            assign s_a[k]    = r_a[k];
            assign s_bx[k]   = r_bx[k];
            assign s_sum[k]  = r_sum[k];
            assign s_c[k]    = r_c[k];
         end

         logic [NG-1:0]    gp;
         logic [NG-1:0]    gg;
         logic [NG-1:0]    gco_unused;
         logic [NG:0]      gc;
         logic [SW-1:0]    ssum;
         logic [WIDTH-1:0] nsum;
         logic             cterm;
         logic             cacc;

         for (genvar g = 0; g < NG; g++) begin : g_grp
            cla_group4 u_grp (
               .a    (s_a[k][k*SW + g*CLA_GRP +: CLA_GRP]),
               .b    (s_bx[k][k*SW + g*CLA_GRP +: CLA_GRP]),
               .cin  (gc[g]),
               .sum  (ssum[g*CLA_GRP +: CLA_GRP]),
               .gp   (gp[g]),
               .gg   (gg[g]),
               .cout (gco_unused[g])
            );
         end

         // Group-level lookahead: every group carry-in is a flat sum of products
         always_comb begin
            gc    = '0;
            cterm = 1'b0;
            cacc  = 1'b0;
            gc[0] = s_c[k];
            for (int g = 0; g < NG; g++) begin
               cterm = s_c[k];
               for (int j = 0; j <= g; j++) cterm = cterm & gp[j];
               cacc = cterm;
               for (int j = 0; j <= g; j++) begin
                  cterm = gg[j];
                  for (int h = j + 1; h <= g; h++) cterm = cterm & gp[h];
                  cacc = cacc | cterm;
               end
               gc[g+1] = cacc;
            end
         end

         always_comb begin
            nsum = s_sum[k];
            nsum[k*SW +: SW] = ssum;
         end

         assign n_sum[k] = nsum;
         assign n_c[k]   = gc[NG];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < STAGES; i++) begin
            r_vld[i]  <= 1'b0;
            r_mode[i] <= '0;
            r_a[i]    <= '0;
            r_bx[i]   <= '0;
            r_sum[i]  <= '0;
            r_c[i]    <= 1'b0;
         end
      end else if (adv) begin
         for (int i = 1; i < STAGES; i++) begin
            r_vld[i]  <= s_vld[i-1];
            r_mode[i] <= s_mode[i-1];
            r_a[i]    <= s_a[i-1];
            r_bx[i]   <= s_bx[i-1];
            r_sum[i]  <= n_sum[i-1];
            r_c[i]    <= n_c[i-1];
         end
      end
   end

   logic             a_msb;
   logic             raw_ovfl;
   logic             sat;
   logic [WIDTH-1:0] fin;

   // Saturation direction follows the sign of A: overflow only happens away from it
   always_comb begin
      a_msb    = s_a[L][WIDTH-1];
      raw_ovfl = (a_msb == s_bx[L][WIDTH-1]) && (n_sum[L][WIDTH-1] != a_msb);
      sat      = raw_ovfl && ((s_mode[L] == SADD) || (s_mode[L] == SSUB));
      fin      = n_sum[L];
      if (sat) fin = a_msb ? SMIN : SMAX;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         cout      <= 1'b0;
         ovfl      <= 1'b0;
         zero      <= 1'b0;
         neg       <= 1'b0;
      end else if (adv) begin
         out_valid <= s_vld[L];
         result    <= fin;
         cout      <= n_c[L];
         ovfl      <= raw_ovfl;
         zero      <= (fin == '0);
         neg       <= fin[WIDTH-1];
      end
   end

endmodule
